// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Purpose:
//   Turns one core load/store request at a time into a single access on a
//   synchronous SRAM port. It also formats the load data and flags requests
//   that cannot be serviced. The request is accepted only in IDLE. The
//   responder then runs ACCESS (one mem_en pulse), WAIT (loads only, to
//   capture the SRAM read data) and RESP (one-cycle rsp_valid pulse).
//   A request with an illegal size code skips ACCESS and goes straight to
//   RESP with err=1.
//
// Optional feature:
//   DMEM_MISALIGN_TRAP_EN
//     Defined:   a misaligned half/word request is rejected like an illegal
//                size code (no SRAM access, err=1, rdata=0).
//     Undefined: the offending low address bits are cleared and the access
//                goes ahead without error.
//
// Parameters:
//   MEM_AW       word-address width of the backing SRAM (4*2^MEM_AW bytes)
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   req_valid    core presents a load/store request
//   req_ready    high in IDLE; request accepted when req_valid is also high
//   MemRW        0 = load, 1 = store
//   DatasizeSel  funct3 size code
//   addr         byte address (bits above MEM_AW+1 ignored, address wraps)
//   wdata        store data, right-aligned
//   rsp_valid    one-cycle completion pulse
//   rdata        formatted load data, zero when rsp_valid is low
//   err          request rejected, zero when rsp_valid is low
//   mem_en       SRAM enable, only in ACCESS
//   mem_we       SRAM write enable
//   mem_be       SRAM byte-lane enables
//   mem_addr     SRAM word address
//   mem_wdata    SRAM write data (lanes replicated for byte/half stores)
//   mem_rdata    SRAM read data, valid the cycle after mem_en
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              MemRW,
  input  logic [2:0]        DatasizeSel,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              rsp_valid,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]        r_state;
  logic              r_we;
  logic [2:0]        r_size;
  logic [MEM_AW+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic [31:0]       r_rdata;

  logic              w_isByte;
  logic              w_isHalf;
  logic              w_isWord;
  logic              w_illegal;
  logic              w_misalign;
  logic              w_reject;
  logic [MEM_AW+1:0] w_alignedAddr;
  logic              w_unusedAddrBits;
  logic [31:0]       w_shifted;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_loadData;
  logic [3:0]        w_storeBe;
  logic [31:0]       w_storeData;
  logic              w_inAccess;
  logic              w_storeAccess;

  // Address bits above the SRAM range only make the address wrap.
  assign w_unusedAddrBits = &{1'b0, addr[31:MEM_AW+2]};

  // Classify the incoming request. Signed/unsigned pairs share a width:
  // the low two bits give the width and bit 2 selects zero-extension.
  // Codes 011/110/111 are illegal. An unsigned size makes no sense for a
  // store, so 100/101 with MemRW=1 is illegal too.
  always_comb begin
    w_isByte   = (DatasizeSel[1:0] == 2'b00);
    w_isHalf   = (DatasizeSel[1:0] == 2'b01);
    w_isWord   = (DatasizeSel == 3'b010);
    w_illegal  = (DatasizeSel == 3'b011) || (DatasizeSel[2] && DatasizeSel[1]) ||
                 (MemRW && DatasizeSel[2]);
    w_misalign = (w_isHalf && addr[0]) || (w_isWord && (addr[1:0] != 2'b00));
`ifdef DMEM_MISALIGN_TRAP_EN
    w_reject   = w_illegal || w_misalign;
`else
    w_reject   = w_illegal;
`endif
    // Only the non-trapping build depends on this masking. With the trap
    // enabled, a misaligned request never reaches the SRAM.
    w_alignedAddr = {addr[MEM_AW+1:2],
                     addr[1] && !w_isWord,
                     addr[0] && !(w_isHalf || w_isWord)};
  end

  // Request capture and sequencing. Reset has priority, so nothing is
  // accepted in a reset cycle, and any in-flight access is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_size  <= 3'b000;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_err   <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we    <= MemRW;
            r_size  <= DatasizeSel;
            r_addr  <= w_alignedAddr;
            r_wdata <= wdata;
            r_err   <= w_reject;
            r_rdata <= 32'h0;
            r_state <= w_reject ? S_RESP : S_ACCESS;
          end
        end
        S_ACCESS: r_state <= r_we ? S_RESP : S_WAIT;
        S_WAIT: begin
          r_rdata <= w_loadData;
          r_state <= S_RESP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Load formatting: pick the addressed lane from the SRAM word, then sign-
  // or zero-extend it.
  always_comb begin
    w_shifted = mem_rdata >> {r_addr[1:0], 3'b000};
    w_byte    = w_shifted[7:0];
    w_half    = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_size)
      3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
      3'b100:  w_loadData = {24'h0, w_byte};
      3'b101:  w_loadData = {16'h0, w_half};
      default: w_loadData = mem_rdata;
    endcase
  end

  // Store lane enables and data. Byte and half data are copied into every
  // lane, so mem_be alone decides which bytes change.
  always_comb begin
    case (r_size[1:0])
      2'b00: begin
        w_storeBe   = 4'b0001 << r_addr[1:0];
        w_storeData = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_storeBe   = 4'b0011 << r_addr[1:0];
        w_storeData = {2{r_wdata[15:0]}};
      end
      default: begin
        w_storeBe   = 4'b1111;
        w_storeData = r_wdata;
      end
    endcase
  end

  // Outputs are gated with rst so that a reset arriving mid-operation
  // suppresses the SRAM access and the response in that same cycle.
  always_comb begin
    w_inAccess    = (r_state == S_ACCESS) && !rst;
    w_storeAccess = w_inAccess && r_we;
    req_ready     = (r_state == S_IDLE);
    mem_en        = w_inAccess;
    mem_we        = w_storeAccess;
    mem_be        = w_storeAccess ? w_storeBe : 4'b0000;
    mem_addr      = w_inAccess ? r_addr[MEM_AW+1:2] : '0;
    mem_wdata     = w_storeAccess ? w_storeData : 32'h0;
    rsp_valid     = (r_state == S_RESP) && !rst;
    rdata         = (rsp_valid && !r_err) ? r_rdata : 32'h0;
    err           = rsp_valid && r_err;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Purpose:
//   Scoreboard bench for dmem_responder. The driver issues one request at a
//   time. For each request it asks a byte-array reference model for the
//   expected SRAM access and response, and queues both. A monitor pops and
//   compares whenever the DUT enables the SRAM or presents rsp_valid.
//   A behavioural SRAM model sits on the memory port. Honours
//   DMEM_MISALIGN_TRAP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int AW = 10;
  localparam int NW = 1 << AW;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          MemRW;
  logic [2:0]    DatasizeSel;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic          rsp_valid;
  logic [31:0]   rdata;
  logic          err;
  logic          mem_en;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        isLoad;
    int          issueCyc;
    int          lat;
  } rspExp_t;

  typedef struct {
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] word;
  } accExp_t;

  rspExp_t     rspQ[$];
  accExp_t     accQ[$];
  logic [7:0]  refMem[4*NW];
  logic [31:0] sram[NW];
  logic [31:0] memRd;
  bit          memInit = 1'b0;
  bit          monOn   = 1'b0;
  int          cyc     = 0;
  int          nCompare = 0;
  int          nFail    = 0;

  dmem_responder #(.MEM_AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .MemRW       (MemRW),
    .DatasizeSel (DatasizeSel),
    .addr        (addr),
    .wdata       (wdata),
    .rsp_valid   (rsp_valid),
    .rdata       (rdata),
    .err         (err),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_be      (mem_be),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Deterministic pseudo-random power-up contents shared by SRAM and model.
  function automatic logic [31:0] seedWord(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  // Behavioural synchronous SRAM: byte-masked write, registered read.
  always @(posedge clk) begin
    if (!memInit) begin
      for (int i = 0; i < NW; i++) sram[i] <= seedWord(i);
      memInit <= 1'b1;
    end else if (mem_en) begin
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      memRd <= sram[mem_addr];
    end
  end
  assign mem_rdata = memRd;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompare++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model over a flat byte array: sizes in bytes, wrap by modulo,
  // alignment by rounding down, sign extension by subtracting 2^bits.
  task automatic refModel(input logic we, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, output rspExp_t r, output accExp_t x,
                          output bit hasAcc);
    int     nb;
    bit     sgn;
    bit     legal;
    bit     mis;
    bit     reject;
    int     ea;
    longint v;
    nb = 0; sgn = 1'b0;
    case (sz)
      3'd0: begin nb = 1; sgn = 1'b1; end
      3'd1: begin nb = 2; sgn = 1'b1; end
      3'd2: begin nb = 4; sgn = 1'b0; end
      3'd4: begin nb = 1; sgn = 1'b0; end
      3'd5: begin nb = 2; sgn = 1'b0; end
      default: nb = 0;
    endcase
    legal = (nb != 0) && !(we && sz[2]);
    ea = int'(a & 32'(4*NW - 1));
    mis = 1'b0;
    if (legal) mis = (ea % nb) != 0;
`ifdef DMEM_MISALIGN_TRAP_EN
    reject = !legal || mis;
`else
    reject = !legal;
`endif
    r.err = reject; r.rdata = 32'h0; r.isLoad = !we; r.issueCyc = cyc;
    r.lat = reject ? 1 : (we ? 2 : 3);
    x.we = we; x.be = 4'b0000; x.word = '0;
    hasAcc = !reject;
    if (!reject) begin
      ea = ea - (ea % nb);
      x.word = AW'(ea / 4);
      if (we) begin
        for (int i = 0; i < nb; i++) begin
          refMem[ea + i] = wd[8*i +: 8];
          x.be[(ea % 4) + i] = 1'b1;
        end
      end else begin
        v = 0;
        for (int i = 0; i < nb; i++) v = v + (longint'(refMem[ea + i]) << (8*i));
        if (sgn && nb < 4 && v >= (64'sd1 << (8*nb - 1))) v = v - (64'sd1 << (8*nb));
        r.rdata = v[31:0];
      end
    end
  endtask

  // Issue one request once the DUT is idle; while it is busy, random
  // garbage is presented on req_valid to show it is ignored.
  task automatic applyStimulus(input logic we, input logic [2:0] sz, input logic [31:0] a,
                               input logic [31:0] wd);
    rspExp_t r;
    accExp_t x;
    bit      hasAcc;
    int      n;
    n = 0;
    @(negedge clk);
    while (!req_ready) begin
      req_valid = 1'($urandom); MemRW = 1'($urandom); DatasizeSel = 3'($urandom);
      addr = $urandom; wdata = $urandom;
      n++;
      if (n > 20) begin
        checkOutput("req_ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    req_valid = 1'b1; MemRW = we; DatasizeSel = sz; addr = a; wdata = wd;
    refModel(we, sz, a, wd, r, x, hasAcc);
    rspQ.push_back(r);
    if (hasAcc) accQ.push_back(x);
    @(negedge clk);
    req_valid = 1'b0; addr = $urandom; wdata = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rspQ.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (rspQ.size() != 0) checkOutput("drain_timeout", 32'(rspQ.size()), 32'd0);
  endtask

  // Monitor: compares every SRAM access and every response against the
  // queued expectations, and checks that outputs stay quiet otherwise.
  always @(negedge clk) begin
    accExp_t x;
    rspExp_t r;
    #2;
    if (monOn) begin
      if (mem_en) begin
        if (accQ.size() == 0) checkOutput("unexpected_mem_en", 32'(mem_en), 32'd0);
        else begin
          x = accQ.pop_front();
          checkOutput("mem_we", 32'(mem_we), 32'(x.we));
          checkOutput("mem_addr", 32'(mem_addr), 32'(x.word));
          if (x.we) checkOutput("mem_be", 32'(mem_be), 32'(x.be));
        end
      end else begin
        checkOutput("quiet_mem_we", 32'(mem_we), 32'd0);
        checkOutput("quiet_mem_be", 32'(mem_be), 32'd0);
      end
      if (rsp_valid) begin
        if (rspQ.size() == 0) checkOutput("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
        else begin
          r = rspQ.pop_front();
          checkOutput("rsp_err", 32'(err), 32'(r.err));
          checkOutput("rsp_latency", 32'(cyc - r.issueCyc), 32'(r.lat));
          if (r.isLoad || r.err) checkOutput("rsp_rdata", rdata, r.rdata);
        end
      end else begin
        checkOutput("quiet_rdata", rdata, 32'h0);
        checkOutput("quiet_err", 32'(err), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] ra;
    for (int i = 0; i < NW; i++)
      for (int b = 0; b < 4; b++) refMem[4*i + b] = seedWord(i) >> (8*b);
    rst = 1'b1; req_valid = 1'b0; MemRW = 1'b0; DatasizeSel = 3'b0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    // Reset state, observed while reset is still asserted.
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_be", 32'(mem_be), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    monOn = 1'b1;

    // Directed coverage of the main formats and boundary cases.
    applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0);
    applyStimulus(1'b1, 3'b000, 32'h13, 32'h00000080);
    applyStimulus(1'b0, 3'b000, 32'h13, 32'h0);
    applyStimulus(1'b0, 3'b100, 32'h13, 32'h0);
    applyStimulus(1'b1, 3'b001, 32'h22, 32'h00008001);
    applyStimulus(1'b0, 3'b001, 32'h22, 32'h0);
    applyStimulus(1'b0, 3'b010, 32'h21, 32'h0);
    applyStimulus(1'b1, 3'b100, 32'h40, 32'h12345678);
    applyStimulus(1'b0, 3'b111, 32'h10, 32'h0);
    applyStimulus(1'b0, 3'b010, 32'h10 + 32'(4*NW), 32'h0);
    applyStimulus(1'b1, 3'b010, 32'h30, 32'h11223344);
    drain();

    // Reset during the ACCESS cycle of a store: no SRAM write, no response,
    // and a request presented during reset is not accepted.
    @(negedge clk);
    req_valid = 1'b1; MemRW = 1'b1; DatasizeSel = 3'b010; addr = 32'h30; wdata = 32'hCAFEF00D;
    @(negedge clk);
    rst = 1'b1; MemRW = 1'b0; addr = 32'h0;
    #1;
    checkOutput("abort_mem_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    #1;
    checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk);
    applyStimulus(1'b0, 3'b010, 32'h30, 32'h0);
    drain();

    // Randomised traffic concentrated on a small window for frequent reuse.
    for (int t = 0; t < 300; t++) begin
      ra = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
      applyStimulus(1'($urandom), 3'($urandom), ra, $urandom);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nCompare, nFail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, word-address width of the backing SRAM (4*2^MEM_AW bytes).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-004 SHALL have port req_valid, input, 1, core presents a load/store request.
REQ-005 SHALL have port req_ready, output, 1, responder accepts the request this cycle.
REQ-006 SHALL have port MemRW, input, 1, 0 = load, 1 = store.
REQ-007 SHALL have port DatasizeSel, input, 3, funct3 size code.
REQ-008 SHALL have port addr, input, 32, byte address.
REQ-009 SHALL have port wdata, input, 32, store data, right-aligned.
REQ-010 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port rdata, output, 32, formatted load data, valid with rsp_valid.
REQ-012 SHALL have port err, output, 1, request rejected, valid with rsp_valid.
REQ-013 SHALL have ports mem_en (out, 1), mem_we (out, 1), mem_be (out, 4), mem_addr (out, MEM_AW), mem_wdata (out, 32), mem_rdata (in, 32): synchronous SRAM port, read data valid one cycle after mem_en.

Function
REQ-014 SHALL implement FSM IDLE, ACCESS, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-015 SHALL, in IDLE, on req_valid&&req_ready, register MemRW, DatasizeSel, addr, wdata and go to ACCESS; req_valid while busy is ignored (no queueing).
REQ-016 SHALL, in ACCESS, assert mem_en for exactly one cycle with mem_addr = addr[MEM_AW+1:2]; store -> RESP, load -> WAIT.
REQ-017 SHALL, in WAIT, register mem_rdata and go to RESP; in RESP assert rsp_valid one cycle and return to IDLE.
REQ-018 SHALL give latency accept-to-rsp_valid of 2 cycles for stores and 3 cycles for loads; next accept earliest the cycle after RESP.
REQ-019 SHALL decode DatasizeSel: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; 011/110/111 illegal; 100/101 with MemRW=1 illegal.
REQ-020 SHALL, for stores, drive mem_we=1, mem_be = 0001<<addr[1:0] (byte), 0011<<addr[1:0] (half), 1111 (word), and replicate wdata low byte/half across mem_wdata lanes.
REQ-021 SHALL, for loads, select byte lane addr[1:0] or half lane addr[1] from registered data and sign- or zero-extend to 32 bits per REQ-019.
REQ-022 SHALL treat a request as misaligned when half with addr[0]=1 or word with addr[1:0]!=00.
REQ-023 SHALL, for an illegal size code, skip ACCESS (no mem_en), go IDLE->RESP, assert err=1, rdata=0.
REQ-024 SHALL hold rdata=0 and err=0 whenever rsp_valid=0; mem_en, mem_we, mem_be SHALL be 0 outside ACCESS.
REQ-025 SHALL ignore addr bits above MEM_AW+1 (address wraps modulo SRAM size).

Reset
REQ-026 SHALL, on rst=1, force state IDLE and req_ready=1 (IDLE), rsp_valid=0, rdata=0, err=0, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
REQ-027 SHALL abort any in-flight access on rst asserted mid-operation: no rsp_valid produced, a store in ACCESS that cycle SHALL NOT reach the SRAM (mem_en forced 0).
REQ-028 SHALL not accept a request in the cycle rst=1.

Configuration
REQ-029 SHALL, with macro DMEM_MISALIGN_TRAP_EN defined, handle a misaligned request like an illegal one (REQ-023: no SRAM access, err=1, rdata=0).
REQ-030 SHALL, without DMEM_MISALIGN_TRAP_EN, clear the offending low address bits (half: addr[0]=0; word: addr[1:0]=00), perform the access, and never assert err for misalignment.

Verification
REQ-031 SHALL cover: store word 0xDEADBEEF at 0x10, then load word 0x10 -> mem_be=1111, rsp 2 cycles after store accept, rdata=0xDEADBEEF 3 cycles after load accept.
REQ-032 SHALL cover: store byte 0x80 at 0x13, load byte signed/unsigned 0x13 -> mem_be=1000, rdata=0xFFFFFF80 then 0x00000080.
REQ-033 SHALL cover: store half 0x8001 at 0x22, load half signed 0x22 -> mem_be=1100, rdata=0xFFFF8001.
REQ-034 SHALL cover: load word at 0x21 -> with DMEM_MISALIGN_TRAP_EN err=1, rdata=0, no mem_en; without it reads word 0x20, err=0.
REQ-035 SHALL cover: DatasizeSel=100 with MemRW=1 -> err=1, no mem_we, rsp 1 cycle after accept.
REQ-036 SHALL cover: rst asserted in ACCESS of a store to 0x30 -> mem_en=0 that cycle, no rsp_valid, later load 0x30 returns prior contents.
